// File: rtl/alarm_ctrl.sv
// Alarm sequencer: stores a BCD alarm time, rings on a match with the running
// clock, and supports bounded snoozing, dismissal and auto-stop after a ring timeout.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] cur_hr,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    input  logic       set_en,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic       alarm_on,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] alm_hr,
    output logic [7:0] alm_min,
    output logic [1:0] state,
    output logic       buzzer,
    output logic [1:0] snooze_cnt
);

    localparam int RW = $clog2(RING_SECS + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
    localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } state_t;

    state_t        state_reg;
    logic          buzzer_reg;
    logic [1:0]    snooze_cnt_reg;
    logic [RW-1:0] ring_cnt_reg;
    logic [SW-1:0] snz_cnt_reg;
    logic [7:0]    alm_hr_reg;
    logic [7:0]    alm_min_reg;

    logic [15:0] set_pair;
    logic [3:0]  nib_ok;
    logic        set_ok;
    logic        set_accept;
    logic        match;
    logic        force_idle;
    logic        snooze_take;

    assign set_pair = {set_hr, set_min};

    // Every nibble of the requested time must be a decimal digit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            logic [3:0] nib;
            assign nib        = set_pair[gi*4 +: 4];
            assign nib_ok[gi] = (nib <= 4'd9);
        end
    endgenerate

    assign set_ok     = (&nib_ok) && (set_hr <= 8'h23) && (set_min <= 8'h59);
    assign set_accept = set_en && set_ok;

    assign match = tick && alarm_on &&
                   (cur_hr == alm_hr_reg) && (cur_min == alm_min_reg) &&
                   (cur_sec == 8'h00);

    // Stop only acts while an alarm event is in progress; the others always abort.
    assign force_idle  = (stop && (state_reg != IDLE)) || !alarm_on || set_accept;
    assign snooze_take = snooze && (state_reg == RING) && (snooze_cnt_reg < MAX_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            buzzer_reg     <= 1'b0;
            snooze_cnt_reg <= 2'd0;
            ring_cnt_reg   <= '0;
            snz_cnt_reg    <= '0;
            alm_hr_reg     <= 8'h00;
            alm_min_reg    <= 8'h00;
        end else begin
            if (set_accept) begin
                alm_hr_reg  <= set_hr;
                alm_min_reg <= set_min;
            end

            if (force_idle) begin
                state_reg      <= IDLE;
                buzzer_reg     <= 1'b0;
                snooze_cnt_reg <= 2'd0;
                ring_cnt_reg   <= '0;
                snz_cnt_reg    <= '0;
            end else if (snooze_take) begin
                state_reg      <= SNOOZE;
                buzzer_reg     <= 1'b0;
                snooze_cnt_reg <= snooze_cnt_reg + 2'd1;
                ring_cnt_reg   <= '0;
                snz_cnt_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (match) begin
                            state_reg      <= RING;
                            buzzer_reg     <= 1'b1;
                            snooze_cnt_reg <= 2'd0;
                            ring_cnt_reg   <= '0;
                            snz_cnt_reg    <= '0;
                        end
                    end
                    RING: begin
                        if (tick) begin
                            if (ring_cnt_reg == RING_LAST) begin
                                state_reg      <= IDLE;
                                buzzer_reg     <= 1'b0;
                                snooze_cnt_reg <= 2'd0;
                                ring_cnt_reg   <= '0;
                            end else begin
                                ring_cnt_reg <= ring_cnt_reg + RW'(1);
                            end
                        end
                    end
                    SNOOZE: begin
                        if (tick) begin
                            if (snz_cnt_reg == SNOOZE_LAST) begin
                                state_reg    <= RING;
                                buzzer_reg   <= 1'b1;
                                ring_cnt_reg <= '0;
                                snz_cnt_reg  <= '0;
                            end else begin
                                snz_cnt_reg <= snz_cnt_reg + SW'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg      <= IDLE;
                        buzzer_reg     <= 1'b0;
                        snooze_cnt_reg <= 2'd0;
                        ring_cnt_reg   <= '0;
                        snz_cnt_reg    <= '0;
                    end
                endcase
            end
        end
    end

    assign alm_hr     = alm_hr_reg;
    assign alm_min    = alm_min_reg;
    assign state      = state_reg;
    assign buzzer     = buzzer_reg;
    assign snooze_cnt = snooze_cnt_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the alarm rules.
module tb_alarm_ctrl;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] cur_hr = 8'h00, cur_min = 8'h00, cur_sec = 8'h00;
    logic       set_en = 1'b0;
    logic [7:0] set_hr = 8'h00, set_min = 8'h00;
    logic       alarm_on = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] alm_hr, alm_min;
    logic [1:0] state;
    logic       buzzer;
    logic [1:0] snooze_cnt;

    alarm_ctrl #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cur_hr    (cur_hr),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .set_en    (set_en),
        .set_hr    (set_hr),
        .set_min   (set_min),
        .alarm_on  (alarm_on),
        .snooze    (snooze),
        .stop      (stop),
        .alm_hr    (alm_hr),
        .alm_min   (alm_min),
        .state     (state),
        .buzzer    (buzzer),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tsec   = 0;

    // Model: mode 0 idle, 1 ringing, 2 snoozing; elapsed ticks in the current phase.
    int m_mode = 0;
    int m_elapsed = 0;
    int m_used = 0;
    int m_ahr = 0;
    int m_amin = 0;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd_val(b) <= maxv);
    endfunction

    function automatic logic [20:0] dut_vec();
        return {state, buzzer, snooze_cnt, alm_hr, alm_min};
    endfunction

    function automatic logic [20:0] exp_vec();
        return {2'(m_mode), (m_mode == 1), 2'(m_used), bcd(m_ahr), bcd(m_amin)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_used = 0; m_ahr = 0; m_amin = 0;
    endtask

    task automatic model_update();
        bit valid, hit;
        valid = set_en && bcd_ok(set_hr, 23) && bcd_ok(set_min, 59);
        hit = tick && alarm_on && bcd_val(cur_hr) == m_ahr && bcd_val(cur_min) == m_amin &&
              cur_sec == 8'h00;
        if ((stop && m_mode != 0) || !alarm_on || valid) begin
            m_mode = 0; m_elapsed = 0; m_used = 0;
        end else if (snooze && m_mode == 1 && m_used < MAX_SNOOZE) begin
            m_mode = 2; m_elapsed = 0; m_used++;
        end else if (m_mode == 0) begin
            if (hit) begin m_mode = 1; m_elapsed = 0; m_used = 0; end
        end else if (tick) begin
            m_elapsed++;
            if (m_mode == 1 && m_elapsed == RING_SECS) begin
                m_mode = 0; m_elapsed = 0; m_used = 0;
            end else if (m_mode == 2 && m_elapsed == SNOOZE_SECS) begin
                m_mode = 1; m_elapsed = 0;
            end
        end
        if (valid) begin
            m_ahr = bcd_val(set_hr); m_amin = bcd_val(set_min);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_update(); else model_reset();
        #1;
        tick = 1'b0; snooze = 1'b0; stop = 1'b0; set_en = 1'b0;
    endtask

    task automatic tick_once();
        tsec = (tsec + 1) % 86400;
        cur_hr = bcd(tsec / 3600); cur_min = bcd((tsec / 60) % 60); cur_sec = bcd(tsec % 60);
        tick = 1'b1;
        step();
    endtask

    task automatic load_alarm(input logic [7:0] h, input logic [7:0] m);
        set_hr = h; set_min = m; set_en = 1'b1;
        step();
    endtask

    // Place the clock one second before the stored alarm and tick into it.
    task automatic trigger();
        tsec = (m_ahr * 3600 + m_amin * 60 + 86400 - 1) % 86400;
        tick_once();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        if (state !== 2'b00 || buzzer !== 1'b0 || snooze_cnt !== 2'd0 ||
            alm_hr !== 8'h00 || alm_min !== 8'h00) begin
            errors++;
            $display("FAIL reset: got=%h exp=%h", dut_vec(), 21'h0);
        end
        checks++;
        step();
        rst = 1'b1;
        alarm_on = 1'b1;
        step();
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_release: got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_set();
        logic [7:0] bad_h[3] = '{8'h24, 8'h1A, 8'h07};
        logic [7:0] bad_m[3] = '{8'h30, 8'h30, 8'h5A};
        load_alarm(8'h07, 8'h30);
        if (alm_hr !== 8'h07 || alm_min !== 8'h30) begin
            errors++; $display("FAIL set_valid: got=%h:%h exp=07:30", alm_hr, alm_min);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            load_alarm(bad_h[i], bad_m[i]);
            if (alm_hr !== 8'h07 || alm_min !== 8'h30) begin
                errors++;
                $display("FAIL set_invalid_%0d: got=%h:%h exp=07:30", i, alm_hr, alm_min);
            end
            checks++;
        end
    endtask

    task automatic test_ring_timeout();
        tsec = 7 * 3600 + 29 * 60 + 58;
        tick_once();
        if (state !== 2'b00 || buzzer !== 1'b0) begin
            errors++; $display("FAIL pre_match: got st=%0d bz=%0d exp st=0 bz=0", state, buzzer);
        end
        checks++;
        tick_once();
        if (state !== 2'b01 || buzzer !== 1'b1) begin
            errors++; $display("FAIL match_ring: got st=%0d bz=%0d exp st=1 bz=1", state, buzzer);
        end
        checks++;
        for (int i = 1; i < RING_SECS; i++) tick_once();
        if (buzzer !== 1'b1 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL ring_59: got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
        tick_once();
        if (buzzer !== 1'b0 || state !== 2'b00) begin
            errors++; $display("FAIL ring_60: got st=%0d bz=%0d exp st=0 bz=0", state, buzzer);
        end
        checks++;
    endtask

    task automatic test_snooze();
        trigger();
        for (int n = 1; n <= 4; n++) begin
            snooze = 1'b1;
            step();
            if (n <= MAX_SNOOZE) begin
                if (state !== 2'b10 || buzzer !== 1'b0 || snooze_cnt !== 2'(n)) begin
                    errors++;
                    $display("FAIL snooze_%0d: got st=%0d bz=%0d cnt=%0d exp st=2 bz=0 cnt=%0d",
                             n, state, buzzer, snooze_cnt, n);
                end
                checks++;
                for (int i = 1; i < SNOOZE_SECS; i++) tick_once();
                if (state !== 2'b10) begin
                    errors++; $display("FAIL snooze_hold_%0d: got st=%0d exp st=2", n, state);
                end
                checks++;
                tick_once();
                if (state !== 2'b01 || buzzer !== 1'b1) begin
                    errors++;
                    $display("FAIL snooze_wake_%0d: got st=%0d bz=%0d exp st=1 bz=1", n, state, buzzer);
                end
                checks++;
            end else begin
                if (state !== 2'b01 || buzzer !== 1'b1 || snooze_cnt !== 2'd3) begin
                    errors++;
                    $display("FAIL snooze_limit: got st=%0d bz=%0d cnt=%0d exp st=1 bz=1 cnt=3",
                             state, buzzer, snooze_cnt);
                end
                checks++;
            end
        end
    endtask

    task automatic test_stop();
        stop = 1'b1; snooze = 1'b1;
        step();
        if (state !== 2'b00 || snooze_cnt !== 2'd0) begin
            errors++; $display("FAIL stop_limit: got st=%0d cnt=%0d exp 0 0", state, snooze_cnt);
        end
        checks++;
        trigger();
        stop = 1'b1; snooze = 1'b1;
        step();
        if (state !== 2'b00 || snooze_cnt !== 2'd0 || buzzer !== 1'b0) begin
            errors++; $display("FAIL stop_snooze: got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
        stop = 1'b1;
        step();
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL stop_idle: got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_abort();
        trigger();
        snooze = 1'b1;
        step();
        alarm_on = 1'b0;
        step();
        if (state !== 2'b00 || snooze_cnt !== 2'd0) begin
            errors++; $display("FAIL alarm_off: got st=%0d cnt=%0d exp 0 0", state, snooze_cnt);
        end
        checks++;
        trigger();
        if (state !== 2'b00) begin
            errors++; $display("FAIL disarmed_match: got st=%0d exp st=0", state);
        end
        checks++;
        alarm_on = 1'b1;
        trigger();
        load_alarm(8'h00, 8'h00);
        if (state !== 2'b00 || alm_hr !== 8'h00 || alm_min !== 8'h00) begin
            errors++; $display("FAIL set_in_ring: got=%h exp=%h", dut_vec(), exp_vec());
        end
        checks++;
        tsec = 86398;
        tick_once();
        tick_once();
        if (state !== 2'b01 || buzzer !== 1'b1) begin
            errors++; $display("FAIL midnight: got st=%0d bz=%0d exp st=1 bz=1", state, buzzer);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        load_alarm(8'h12, 8'h45);
        trigger();
        snooze = 1'b1;
        step();
        tick_once();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        if (state !== 2'b00 || buzzer !== 1'b0 || snooze_cnt !== 2'd0 ||
            alm_hr !== 8'h00 || alm_min !== 8'h00) begin
            errors++; $display("FAIL async_reset: got=%h exp=%h", dut_vec(), 21'h0);
        end
        checks++;
        step();
        rst = 1'b1;
        for (int i = 0; i < SNOOZE_SECS + 5; i++) tick_once();
        if (state !== 2'b00 || buzzer !== 1'b0) begin
            errors++; $display("FAIL no_resume: got st=%0d bz=%0d exp st=0 bz=0", state, buzzer);
        end
        checks++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 399) == 0) tsec = (m_ahr * 3600 + m_amin * 60 + 86400 - 1 -
                                                     int'($urandom_range(0, 3))) % 86400;
            alarm_on = ($urandom_range(0, 199) != 0);
            snooze   = ($urandom_range(0, 24) == 0);
            stop     = ($urandom_range(0, 149) == 0);
            set_en   = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_hr = 8'($urandom); set_min = 8'($urandom);
            end else begin
                set_hr = bcd($urandom_range(0, 23)); set_min = bcd($urandom_range(0, 59));
            end
            if ($urandom_range(0, 1) == 0) begin
                tsec = (tsec + 1) % 86400;
                cur_hr = bcd(tsec / 3600); cur_min = bcd((tsec / 60) % 60);
                cur_sec = bcd(tsec % 60);
                tick = 1'b1;
            end
            step();
            if (dut_vec() !== exp_vec()) begin
                errors++;
                if (bad < 10) $display("FAIL random_%0d: got=%h exp=%h", c, dut_vec(), exp_vec());
                bad++;
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_ring_timeout();
        test_snooze();
        test_stop();
        test_abort();
        test_async_reset();
        alarm_on = 1'b1;
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
